// File: rtl/stage_render_pkg.sv
// Shared types and width helpers for the scrolling stage background renderer.
package stage_render_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Per-pixel control bits that travel alongside the ROM fetch.
    typedef struct packed {
        logic blank;
        logic oob;
        logic hs;
        logic vs;
    } side_t;

    // Bits needed to hold any value in 0..n-1.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int view_w(input int h_active, input int scale_shift);
        return h_active >> scale_shift;
    endfunction

    function automatic int pipe_lat(input int rom_lat);
        return rom_lat + 2;
    endfunction

endpackage

// File: rtl/stage_scroll_ctrl.sv
// Frame-boundary scroll controller: accepts one scroll request and applies it at frame_tick.
// Wrap or clamp behaviour of the applied value is selected by STAGE_SCROLL_WRAP_EN.
module stage_scroll_ctrl
    import stage_render_pkg::*;
#(
    parameter int SRC_W       = 320,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int SCROLL_W    = 10,
    localparam int CUR_W      = width_of(SRC_W)
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [SCROLL_W-1:0] scroll_x,
    input  logic                scroll_valid,
    output logic                scroll_ready,
    output logic                scroll_applied,
    output logic [CUR_W-1:0]    scroll_cur
);

    localparam int VIEW_W = view_w(H_ACTIVE, SCALE_SHIFT);

    logic                pending;
    logic [SCROLL_W-1:0] pend_val;
    logic                frame_tick;
    logic                accept;

    function automatic logic [CUR_W-1:0] fix(input logic [SCROLL_W-1:0] v);
`ifdef STAGE_SCROLL_WRAP_EN
        if (int'(v) < SRC_W)
            return CUR_W'(v);
        else if (int'(v) < 2 * SRC_W)
            return CUR_W'(int'(v) - SRC_W);
        else
            return CUR_W'(SRC_W - 1);
`else
        if (int'(v) > SRC_W - VIEW_W)
            return CUR_W'(SRC_W - VIEW_W);
        else
            return CUR_W'(v);
`endif
    endfunction

    // First pixel of the first blanked line: scroll_cur may only move here.
    assign frame_tick   = (DrawY == 10'(V_ACTIVE)) && (DrawX == '0);
    assign scroll_ready = ~pending & ~reset;
    assign accept       = scroll_valid & scroll_ready;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pending        <= 1'b0;
            pend_val       <= '0;
            scroll_cur     <= '0;
            scroll_applied <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the pulse default and the conditional set live
            // in one block; every read below sees the pre-edge value of pending.
            scroll_applied <= 1'b0;
            if (frame_tick && pending) begin
                scroll_cur     <= fix(pend_val);
                pending        <= 1'b0;
                scroll_applied <= 1'b1;
            end
            // A request taken on the tick cycle waits for the next tick.
            if (accept) begin
                pending  <= 1'b1;
                pend_val <= scroll_x;
            end
        end
    end

endmodule

// File: rtl/stage_scroll_renderer.sv
// Scaled, horizontally scrolling stage background with external ROM and palette.
// Define STAGE_SCROLL_WRAP_EN for a seamlessly wrapping view; otherwise scrolling clamps.
module stage_scroll_renderer
    import stage_render_pkg::*;
#(
    parameter int SRC_W       = 320,
    parameter int SRC_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ROM_LAT     = 1,
    parameter int IDX_W       = 3,
    parameter int ADDR_W      = 15,
    parameter int SCROLL_W    = 10
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic                hs_in,
    input  logic                vs_in,
    input  logic [SCROLL_W-1:0] scroll_x,
    input  logic                scroll_valid,
    output logic                scroll_ready,
    output logic                scroll_applied,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [IDX_W-1:0]    rom_q,
    output logic [IDX_W-1:0]    pal_idx,
    input  logic [11:0]         pal_rgb,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                hs_out,
    output logic                vs_out
);

    localparam int CUR_W      = width_of(SRC_W);
    localparam int SIDE_DEPTH = pipe_lat(ROM_LAT) - 1;

    logic [CUR_W-1:0] scroll_cur;
    logic [9:0]       vy;
    logic [CUR_W-1:0] sx;
    side_t            side_pipe [SIDE_DEPTH];
    rgb12_t           pix;

    stage_scroll_ctrl #(
        .SRC_W       (SRC_W),
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .SCALE_SHIFT (SCALE_SHIFT),
        .SCROLL_W    (SCROLL_W)
    ) u_ctrl (
        .vga_clk        (vga_clk),
        .reset          (reset),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .scroll_x       (scroll_x),
        .scroll_valid   (scroll_valid),
        .scroll_ready   (scroll_ready),
        .scroll_applied (scroll_applied),
        .scroll_cur     (scroll_cur)
    );

    assign vy = DrawY >> SCALE_SHIFT;

`ifdef STAGE_SCROLL_WRAP_EN
    logic [CUR_W:0] sum;
    assign sum = (CUR_W+1)'(DrawX >> SCALE_SHIFT) + (CUR_W+1)'(scroll_cur);

    always_comb begin
        // NOTE: sx is assigned before the conditional so no path leaves it unassigned (no latch).
        sx = sum[CUR_W-1:0];
        if (int'(sum) >= SRC_W)
            sx = CUR_W'(int'(sum) - SRC_W);
    end
`else
    // Clamped scroll keeps vx + scroll_cur below SRC_W across the visible view.
    assign sx = CUR_W'(DrawX >> SCALE_SHIFT) + scroll_cur;
`endif

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            // NOTE: the whole delay line is cleared, not just the head, so RGB and sync stay
            // dark until fresh pixels have refilled every stage.
            rom_addr <= '0;
            for (int i = 0; i < SIDE_DEPTH; i++)
                side_pipe[i] <= '0;
            pix    <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else begin
            rom_addr     <= ADDR_W'(vy) * ADDR_W'(SRC_W) + ADDR_W'(sx);
            side_pipe[0] <= '{blank: blank, oob: (int'(vy) >= SRC_H), hs: hs_in, vs: vs_in};
            for (int i = 1; i < SIDE_DEPTH; i++)
                side_pipe[i] <= side_pipe[i-1];
            if (side_pipe[SIDE_DEPTH-1].blank && !side_pipe[SIDE_DEPTH-1].oob)
                pix <= rgb12_t'(pal_rgb);
            else
                pix <= '0;
            hs_out <= side_pipe[SIDE_DEPTH-1].hs;
            vs_out <= side_pipe[SIDE_DEPTH-1].vs;
        end
    end

    assign pal_idx = rom_q;
    assign red     = pix.r;
    assign green   = pix.g;
    assign blue    = pix.b;

endmodule

// File: tb/tb_stage_scroll_renderer.sv
// Randomised bench for stage_scroll_renderer against a frame-level reference model.
// Builds in wrap or clamp mode depending on STAGE_SCROLL_WRAP_EN.
module tb_stage_scroll_renderer;

    localparam int SRC_W       = 320;
    localparam int SRC_H       = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int ROM_LAT     = 1;
    localparam int IDX_W       = 3;
    localparam int ADDR_W      = 16;
    localparam int SCROLL_W    = 10;
    localparam int VIEW_W      = H_ACTIVE >> SCALE_SHIFT;
    localparam int DEPTH       = ROM_LAT + 2;

`ifdef STAGE_SCROLL_WRAP_EN
    localparam int T3A_ADDR = 139;
    localparam int T3B_ADDR = 319;
    localparam int T4_ADDR  = 38084;
`else
    localparam int T3A_ADDR = 319;
    localparam int T3B_ADDR = 160;
    localparam int T4_ADDR  = 38245;
`endif

    logic                vga_clk = 1'b0;
    logic                reset = 1'b1;
    logic [9:0]          DrawX = '0;
    logic [9:0]          DrawY = '0;
    logic                blank = 1'b0;
    logic                hs_in = 1'b0;
    logic                vs_in = 1'b0;
    logic [SCROLL_W-1:0] scroll_x = '0;
    logic                scroll_valid = 1'b0;
    logic                scroll_ready;
    logic                scroll_applied;
    logic [ADDR_W-1:0]   rom_addr;
    logic [IDX_W-1:0]    rom_q;
    logic [IDX_W-1:0]    pal_idx;
    logic [11:0]         pal_rgb;
    logic [3:0]          red, green, blue;
    logic                hs_out, vs_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 vga_clk = ~vga_clk;

    stage_scroll_renderer #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_SHIFT(SCALE_SHIFT), .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE), .ROM_LAT(ROM_LAT), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
        .SCROLL_W(SCROLL_W)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .hs_in(hs_in), .vs_in(vs_in), .scroll_x(scroll_x), .scroll_valid(scroll_valid),
        .scroll_ready(scroll_ready), .scroll_applied(scroll_applied), .rom_addr(rom_addr),
        .rom_q(rom_q), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .red(red), .green(green),
        .blue(blue), .hs_out(hs_out), .vs_out(vs_out)
    );

    // Stage image and palette contents
    function automatic logic [IDX_W-1:0] rom_of(input int a);
        return IDX_W'(a * 5 + (a >> 4));
    endfunction

    function automatic logic [11:0] pal_of(input logic [IDX_W-1:0] i);
        return 12'(12'h1F3 * (int'(i) + 1)) ^ 12'h804;
    endfunction

    function automatic int fix_model(input int v);
`ifdef STAGE_SCROLL_WRAP_EN
        if (v < SRC_W) return v;
        if (v < 2 * SRC_W) return v - SRC_W;
        return SRC_W - 1;
`else
        return (v < SRC_W - VIEW_W) ? v : SRC_W - VIEW_W;
`endif
    endfunction

    // External ROM with ROM_LAT cycles of read latency
    logic [IDX_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_of(int'(rom_addr));
        for (int i = 1; i < ROM_LAT; i++)
            rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q   = rom_pipe[ROM_LAT-1];
    assign pal_rgb = pal_of(pal_idx);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each sampled pixel must become, and the scroll state it sees.
    typedef struct {
        int addr;
        bit inb;
        int rgb;
        bit hs;
        bit vs;
    } exp_t;

    exp_t q [$];
    int   m_cur = 0;
    int   m_pv = 0;
    bit   m_pending = 0;
    bit   m_applied = 0;
    bit   model_on = 0;

    initial begin
        int   vx, vy;
        exp_t e;
        forever begin
            @(posedge vga_clk);
            if (reset) begin
                q.delete();
                for (int i = 0; i < DEPTH; i++)
                    q.push_back('{addr: 0, inb: 1'b1, rgb: 0, hs: 1'b0, vs: 1'b0});
                m_cur = 0; m_pv = 0; m_pending = 0; m_applied = 0;
                model_on = 1;
            end else if (model_on) begin
                vx = int'(DrawX) >> SCALE_SHIFT;
                vy = int'(DrawY) >> SCALE_SHIFT;
                e.addr = vy * SRC_W + (vx + m_cur) % SRC_W;
                e.inb  = vy < SRC_H;
                e.rgb  = (blank && e.inb) ? int'(pal_of(rom_of(e.addr))) : 0;
                e.hs   = hs_in;
                e.vs   = vs_in;
                q.push_back(e);
                void'(q.pop_front());
                m_applied = 0;
                if (int'(DrawY) == V_ACTIVE && DrawX == 0 && m_pending) begin
                    m_cur = fix_model(m_pv);
                    m_pending = 0;
                    m_applied = 1;
                end else if (scroll_valid && !m_pending) begin
                    m_pending = 1;
                    m_pv = int'(scroll_x);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        exp_t o, n;
        forever begin
            @(negedge vga_clk);
            if (model_on) begin
                o = q[0];
                n = q[DEPTH-1];
                if (n.inb)
                    check("rom_addr", 32'(rom_addr), 32'(n.addr));
                check("rgb", 32'({red, green, blue}), 32'(o.rgb));
                check("hs_out", 32'(hs_out), 32'(o.hs));
                check("vs_out", 32'(vs_out), 32'(o.vs));
                check("scroll_ready", 32'(scroll_ready), 32'(!m_pending && !reset));
                check("scroll_applied", 32'(scroll_applied), 32'(m_applied));
            end
        end
    end

    task automatic step();
        @(posedge vga_clk);
        #2;
    endtask

    task automatic drive(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
    endtask

    task automatic request(input int v);
        drive(12, 40, 1);
        scroll_x = SCROLL_W'(v);
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
    endtask

    task automatic tick_cycle();
        drive(0, V_ACTIVE, 0);
        step();
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;

        // Address and colour latency from a reset scroll of zero
        drive(4, 8, 1);
        step();
        check("t1_rom_addr", 32'(rom_addr), 32'd641);
        step();
        step();
        check("t1_rgb", 32'({red, green, blue}), 32'(pal_of(rom_of(641))));

        // Request mid-frame, applied only at the frame tick
        drive(10, 100, 1);
        scroll_x = 10'd100;
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
        check("t2_ready_low", 32'(scroll_ready), 32'd0);
        drive(0, 0, 1);
        step();
        check("t2_addr_before_tick", 32'(rom_addr), 32'd0);
        tick_cycle();
        check("t2_applied_pulse", 32'(scroll_applied), 32'd1);
        drive(5, 481, 0);
        step();
        check("t2_applied_single", 32'(scroll_applied), 32'd0);
        drive(0, 0, 1);
        step();
        check("t2_addr_after_tick", 32'(rom_addr), 32'd100);
        check("t2_ready_back", 32'(scroll_ready), 32'd1);

        // Scroll value fixing and right-edge behaviour
        request(300);
        tick_cycle();
        drive(636, 0, 1);
        step();
        check("t3_right_edge", 32'(rom_addr), 32'(T3A_ADDR));
        request(700);
        tick_cycle();
        drive(0, 0, 1);
        step();
        check("t3_large_request", 32'(rom_addr), 32'(T3B_ADDR));

        // Bottom source row, out-of-bounds rows and blanking
        drive(20, 479, 1);
        step();
        check("t4_last_row_addr", 32'(rom_addr), 32'(T4_ADDR));
        step();
        step();
        check("t4_last_row_rgb", 32'({red, green, blue}), 32'(pal_of(rom_of(T4_ADDR))));
        drive(8, 480, 1);
        repeat (3) step();
        check("t4_oob_rgb", 32'({red, green, blue}), 32'd0);
        drive(8, 8, 0);
        repeat (3) step();
        check("t4_blank_rgb", 32'({red, green, blue}), 32'd0);

        // Request on the tick cycle itself waits a whole frame
        drive(0, V_ACTIVE, 0);
        scroll_x = 10'd42;
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
        check("t5_no_pulse", 32'(scroll_applied), 32'd0);
        check("t5_pending", 32'(scroll_ready), 32'd0);
        drive(3, 481, 0);
        step();
        tick_cycle();
        check("t5_next_tick_pulse", 32'(scroll_applied), 32'd1);
        drive(0, 0, 1);
        step();
        check("t5_addr", 32'(rom_addr), 32'd42);

        // Mid-frame reset with a pending request and live sync
        request(50);
        tick_cycle();
        request(77);
        hs_in = 1'b1;
        vs_in = 1'b1;
        drive(40, 200, 1);
        repeat (4) step();
        reset = 1'b1;
        step();
        check("t6_rgb_zero", 32'({red, green, blue}), 32'd0);
        check("t6_hs_zero", 32'(hs_out), 32'd0);
        check("t6_vs_zero", 32'(vs_out), 32'd0);
        check("t6_addr_zero", 32'(rom_addr), 32'd0);
        check("t6_applied_zero", 32'(scroll_applied), 32'd0);
        reset = 1'b0;
        hs_in = 1'b0;
        vs_in = 1'b0;
        drive(0, 0, 1);
        step();
        check("t6_ready_after", 32'(scroll_ready), 32'd1);
        check("t6_scroll_zero", 32'(rom_addr), 32'd0);

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0)
                drive(0, V_ACTIVE, 0);
            else
                drive($urandom_range(0, H_ACTIVE - 1), $urandom_range(0, 524), 1'($urandom));
            hs_in = 1'($urandom);
            vs_in = 1'($urandom);
            scroll_valid = ($urandom_range(0, 9) == 0);
            scroll_x = SCROLL_W'($urandom_range(0, 1023));
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        scroll_valid = 1'b0;
        repeat (DEPTH + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
